// File: rtl/ycr1_arb_pkg.sv
// Shared types and constants for the round-robin arbiter.
package ycr1_arb_pkg;

  // Arbiter FSM states.
  typedef enum logic [0:0] {
    ARB      = 1'b0,
    WAIT_ACK = 1'b1
  } arb_state_e;

  // Width of the ack timeout counter.
  localparam int TMO_CW = 16;

endpackage

// File: rtl/ycr1_rr_pick.sv
// Combinational round-robin picker: finds the first set request
// searching upward from (ptr+1) mod NREQ, wrapping around.
module ycr1_rr_pick #(
  parameter  int NREQ = 4,
  localparam int GW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [GW-1:0]   ptr,
  output logic            found,
  output logic [GW-1:0]   idx
);

  // Scan requesters in rotated priority order; the first hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && req[(int'(ptr) + k) % NREQ]) begin
        found = 1'b1;
        idx   = GW'((int'(ptr) + k) % NREQ);
      end
    end
  end

endmodule

// File: rtl/ycr1_arb_rrn.sv
// Round-robin arbiter for NREQ requesters sharing one slave.
// Grants are held until ack (or until lock extends them), with an
// optional ack timeout that releases a stuck grant.
//
// state    | meaning
// ARB      | no grant active; pick next requester when any req is set
// WAIT_ACK | grant active; hold until ack, lock re-hold, or timeout
module ycr1_arb_rrn
  import ycr1_arb_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int TMO  = 0,
  localparam int GW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] lock,
  input  logic            ack,
  output logic            gnt_vld,
  output logic [GW-1:0]   gnt_idx,
  output logic [NREQ-1:0] gnt_oh,
  output logic            tmo_err
);

  localparam logic [NREQ-1:0] OH_ONE  = NREQ'(1);
  localparam logic [GW-1:0]   PTR_RST = GW'(NREQ - 1);

  arb_state_e      state;
  logic [GW-1:0]   ptr;
  logic            pick_found;
  logic [GW-1:0]   pick_idx;
  logic            hold;
  logic            tmo_hit;

  ycr1_rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Locked and still requesting owner keeps the bus across its ack.
  assign hold = |(lock & req & gnt_oh);

  generate
    if (TMO > 0) begin : g_tmo
      localparam logic [TMO_CW-1:0] TMO_LAST = TMO_CW'(TMO - 1);
      logic [TMO_CW-1:0] cnt;

      // Count WAIT_ACK cycles without ack; any ack or exit restarts it.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          cnt <= '0;
        end else if (state != WAIT_ACK || ack || tmo_hit) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      // Ack takes precedence over an expiring timeout.
      assign tmo_hit = (state == WAIT_ACK) && !ack && (cnt == TMO_LAST);
    end else begin : g_no_tmo
      assign tmo_hit = 1'b0;
    end
  endgenerate

  // Arbiter FSM with registered grant outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ARB;
      ptr     <= PTR_RST;
      gnt_vld <= 1'b0;
      gnt_idx <= '1;
      gnt_oh  <= '0;
      tmo_err <= 1'b0;
    end else begin
      tmo_err <= 1'b0;
      case (state)
        ARB: begin
          if (pick_found) begin
            state   <= WAIT_ACK;
            ptr     <= pick_idx;
            gnt_vld <= 1'b1;
            gnt_idx <= pick_idx;
            gnt_oh  <= OH_ONE << pick_idx;
          end
        end
        WAIT_ACK: begin
          if (ack) begin
            if (!hold) begin
              state   <= ARB;
              gnt_vld <= 1'b0;
              gnt_idx <= '1;
              gnt_oh  <= '0;
            end
          end else if (tmo_hit) begin
            state   <= ARB;
            gnt_vld <= 1'b0;
            gnt_idx <= '1;
            gnt_oh  <= '0;
            tmo_err <= 1'b1;
          end
        end
        default: begin
          state   <= ARB;
          gnt_vld <= 1'b0;
          gnt_idx <= '1;
          gnt_oh  <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/ycr1_arb_rrn.md
YCR1_ARB_RRN -- requirements
Module: ycr1_arb_rrn

Interface
REQ-001 SHALL provide parameter NREQ, default 4, number of requesters (legal 2..16).
REQ-002 SHALL provide parameter TMO, default 0, ack timeout in cycles (0 = timeout disabled, else 1..65535).
REQ-003 SHALL derive localparam GW = max(1, clog2(NREQ)), grant index width.
REQ-004 clk  in  1  clock; all state on rising edge.
REQ-005 rstn  in  1  reset, asynchronous, active-low.
REQ-006 req  in  NREQ  per-requester request, level.
REQ-007 lock  in  NREQ  per-requester lock; holds grant across ack for back-to-back transfers.
REQ-008 ack  in  1  transfer complete from shared slave, single-cycle pulse.
REQ-009 gnt_vld  out  1  a grant is active.
REQ-010 gnt_idx  out  GW  index of granted requester; all-ones when gnt_vld=0.
REQ-011 gnt_oh  out  NREQ  one-hot grant; zero when gnt_vld=0.
REQ-012 tmo_err  out  1  one-cycle pulse on ack timeout.

Function
REQ-013 SHALL implement FSM states ARB, WAIT_ACK.
REQ-014 In ARB with any req set: SHALL select the first set req[i] searching from (ptr+1) mod NREQ upward with wrap; register gnt_vld=1, gnt_idx=i, gnt_oh[i]=1 on next edge; go to WAIT_ACK; ptr<=i.
REQ-015 In ARB with req all-zero: SHALL stay in ARB, outputs idle, ptr unchanged.
REQ-016 Grant latency SHALL be exactly 1 cycle from req sampled in ARB to gnt_vld high.
REQ-017 In WAIT_ACK, grant SHALL be held regardless of req changes until ack or timeout.
REQ-018 On ack with lock[gnt_idx]=1 and req[gnt_idx]=1: SHALL stay in WAIT_ACK, grant unchanged, timeout counter cleared.
REQ-019 On ack otherwise: SHALL drop gnt_vld next cycle and return to ARB; next grant no earlier than 2 cycles after ack (one dead cycle).
REQ-020 ack while in ARB SHALL be ignored.
REQ-021 With TMO>0: 16-bit counter SHALL clear on entry to WAIT_ACK and on ack, increment each WAIT_ACK cycle without ack; at count==TMO-1 without ack SHALL drop grant next cycle, pulse tmo_err one cycle, return to ARB.
REQ-022 ack and timeout in same cycle: ack SHALL win, no tmo_err.
REQ-023 With TMO=0: counter SHALL be absent/constant; tmo_err tied 0.
REQ-024 gnt_oh SHALL always equal decode of gnt_idx when gnt_vld=1; at most one bit set.
REQ-025 Fairness: a continuously requesting, unlocked requester SHALL be granted within NREQ grants.

Reset
REQ-026 On rstn low: state=ARB, ptr=NREQ-1 (req[0] highest priority first), gnt_vld=0, gnt_idx=all-ones, gnt_oh=0, tmo_err=0, counter=0.
REQ-027 Reset asserted mid-grant SHALL drop grant immediately (asynchronous), no tmo_err.
REQ-028 First grant after rstn deassertion SHALL follow REQ-014 from ptr=NREQ-1.

Structure
REQ-029 Package ycr1_arb_pkg SHALL hold FSM state enum (ARB, WAIT_ACK) and TMO counter width constant (16).
REQ-030 Round-robin selection SHALL be a sub-module ycr1_rr_pick (inputs req, ptr; outputs found, idx), combinational, parameterised by NREQ.
REQ-031 All outputs SHALL be registered.

Verification
REQ-032 NREQ=4, reset, req=4'b1111 held, ack each WAIT_ACK cycle -> gnt_idx sequence 0,1,2,3,0 with one dead cycle between grants.
REQ-033 NREQ=4, req=4'b0100 only -> gnt_vld high 1 cycle later with gnt_idx=2, gnt_oh=4'b0100; req dropped before ack -> grant held until ack.
REQ-034 NREQ=4, req=4'b0011, lock[0]=1, three acks -> gnt_idx stays 0 for all three; lock[0]=0 then ack -> next grant gnt_idx=1.
REQ-035 TMO=5, grant to req1, no ack -> gnt_vld falls after 5 WAIT_ACK cycles, tmo_err one-cycle pulse, next grant goes to next requester after 1.
REQ-036 TMO=5, ack on the 5th WAIT_ACK cycle -> normal release, tmo_err stays 0.
REQ-037 rstn pulsed low during WAIT_ACK -> gnt_vld=0, gnt_oh=0, gnt_idx=all-ones immediately; after release req=4'b1000 -> gnt_idx=3.
